pc_fetch_stage: RTL and testbench

//   Program-counter and fetch stage that drives the byte address into InstructionMemory and

---
 rtl/pc_fetch_stage_pkg.sv | 13 +
 rtl/pc_fetch_stage_pc_register.sv | 34 +++
 rtl/pc_fetch_stage.sv | 76 +++++++
 tb/tb_pc_fetch_stage.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants and helpers for the program-counter / fetch stage.
package pc_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_stage_pc_register.sv
// Program counter with reset / redirect / stall / sequential-advance next-PC selection.
module pc_fetch_stage_pc_register
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (reset_i) begin
      pc_d = RESET_PC;
    end else if (redirect_i) begin
      pc_d = align_word(target_i);
    end else if (!stall_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk_i) begin
    pc_q <= pc_d;
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Fetch stage: drives the PC to instruction memory and captures the returned word into IF/ID.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int unsigned IMEM_WORDS_L = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IfIdInstruction,
  output logic [31:0] IfIdPCPlus4,
  output logic        IfIdValid,
  output logic        MisalignErr,
  output logic        OutOfRange
);

  logic [31:0] pc;
  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_plus4_d, pc_plus4_q;
  logic        valid_d, valid_q;
  logic        misalign_d, misalign_q;

  pc_fetch_stage_pc_register #(
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk_i     (Clk),
    .reset_i   (Reset),
    .stall_i   (Stall),
    .redirect_i(Redirect),
    .target_i  (RedirectTarget),
    .pc_o      (pc)
  );

  always_comb begin
    instr_d    = instr_q;
    pc_plus4_d = pc_plus4_q;
    valid_d    = valid_q;
    misalign_d = 1'b0;
    if (Reset) begin
      instr_d    = NOP_WORD;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
    end else if (Redirect) begin
      // Squash whatever was fetched this cycle; it belongs to the wrong path.
      instr_d    = NOP_WORD;
      pc_plus4_d = 32'h0;
      valid_d    = 1'b0;
      misalign_d = |RedirectTarget[1:0];
    end else if (!Stall) begin
      instr_d    = Instruction;
      pc_plus4_d = pc + PC_INC;
      valid_d    = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    instr_q    <= instr_d;
    pc_plus4_q <= pc_plus4_d;
    valid_q    <= valid_d;
    misalign_q <= misalign_d;
  end

  assign Address         = pc;
  assign IfIdInstruction = instr_q;
  assign IfIdPCPlus4     = pc_plus4_q;
  assign IfIdValid       = valid_q;
  assign MisalignErr     = misalign_q;
  // Informational only: memory keeps fetching from the aliased low index bits.
  assign OutOfRange      = (pc >> (IMEM_WORDS_L + 2)) != 32'h0;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios followed by randomized traffic.
module tb_pc_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] instr;
  logic [31:0] address;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        merr;
  logic        oor;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [128];

  // Reference model state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_merr;

  always #5 clk = ~clk;

  assign instr = mem[address[8:2]];

  pc_fetch_stage dut (
    .Clk            (clk),
    .Reset          (reset),
    .Stall          (stall),
    .Redirect       (redirect),
    .RedirectTarget (target),
    .Instruction    (instr),
    .Address        (address),
    .IfIdInstruction(ifid_instr),
    .IfIdPCPlus4    (ifid_pc4),
    .IfIdValid      (ifid_valid),
    .MisalignErr    (merr),
    .OutOfRange     (oor)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model written directly from the cycle rules: memory word i holds i*3, 128 words, aliased.
  task automatic model_edge(input logic rst, input logic st, input logic rd, input logic [31:0] tg);
    if (rst) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_merr = 1'b0;
    end else if (rd) begin
      m_pc = (tg / 4) * 4;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_merr = (tg % 4) != 0;
    end else if (st) begin
      m_merr = 1'b0;
    end else begin
      m_instr = ((m_pc / 4) % 128) * 3;
      m_pc4   = m_pc + 4;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
      m_merr  = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic st, input logic rd, input logic [31:0] tg);
    reset = rst; stall = st; redirect = rd; target = tg;
    model_edge(rst, st, rd, tg);
    @(posedge clk);
    #1;
    chk("address", address, m_pc);
    chk("ifid_instr", ifid_instr, m_instr);
    chk("ifid_pc4", ifid_pc4, m_pc4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("misalign", {31'b0, merr}, {31'b0, m_merr});
    chk("out_of_range", {31'b0, oor}, {31'b0, (m_pc >= 32'd512)});
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 3;
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_merr = 1'b0;

    // Reset for two cycles, then release.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    chk("rst_address", address, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);

    // Free run: words 0,3,6,9 with PC+4 of 4,8,12,16.
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("run0_instr", ifid_instr, 32'd0);
    chk("run0_pc4", ifid_pc4, 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("run3_instr", ifid_instr, 32'd9);
    chk("run3_pc4", ifid_pc4, 32'd16);
    chk("run_address", address, 32'd16);

    // Stall three cycles: everything frozen, then the held word (16/4*3=12) is captured.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_address", address, 32'd16);
    chk("stall_instr", ifid_instr, 32'd9);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("unstall_instr", ifid_instr, 32'd12);

    // Redirect wins over stall.
    step(1'b0, 1'b1, 1'b1, 32'd40);
    chk("redir_address", address, 32'd40);
    chk("redir_valid", {31'b0, ifid_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_instr", ifid_instr, 32'd30);

    // Misaligned target: aligned down, one-cycle error pulse.
    step(1'b0, 1'b0, 1'b1, 32'd42);
    chk("misal_address", address, 32'd40);
    chk("misal_pulse", {31'b0, merr}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("misal_clear", {31'b0, merr}, 32'h0);

    // Out of range target still fetches, aliasing to word 0.
    step(1'b0, 1'b0, 1'b1, 32'd512);
    chk("oor_flag", {31'b0, oor}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("oor_alias_instr", ifid_instr, 32'd0);

    // PC wrap and reset overriding redirect.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_address", address, 32'h0);
    chk("wrap_pc4", ifid_pc4, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h88);
    chk("rst_over_redir", address, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] tg;
      r  = $urandom_range(0, 99);
      tg = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 700);
      step(r < 3, $urandom_range(0, 3) == 0, (r >= 3) && (r < 18), tg);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
